// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed combinationally at accept, held in a shadow register, and committed after the busy period.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CW = 4;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;

    logic signed [63:0] smul;
    logic [63:0]        umul;
    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    // Datapath: signed division runs on magnitudes, then signs are restored
    always_comb begin
        smul   = 64'($signed(A)) * 64'($signed(B));
        umul   = 64'(A) * 64'(B);
        a_neg  = (op == OP_DIV) && A[31];
        b_neg  = (op == OP_DIV) && B[31];
        a_mag  = a_neg ? (32'd0 - A) : A;
        b_mag  = b_neg ? (32'd0 - B) : B;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Next-state: accept only when idle; commit on the last busy cycle
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                if (!dz_q) begin
                    hi_d = res_hi_q;
                    lo_d = res_lo_q;
                end
            end
        end else if (start) begin
            case (op)
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                OP_MULT, OP_MULTU: begin
                    busy_d   = 1'b1;
                    cnt_d    = CW'(MULT_CYCLES);
                    dz_d     = 1'b0;
                    res_hi_d = (op == OP_MULT) ? smul[63:32] : umul[63:32];
                    res_lo_d = (op == OP_MULT) ? smul[31:0]  : umul[31:0];
                end
                OP_DIV, OP_DIVU: begin
                    busy_d   = 1'b1;
                    cnt_d    = CW'(DIV_CYCLES);
                    dz_d     = (B == 32'd0);
                    res_hi_d = rem;
                    res_lo_d = quot;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: timing of busy, HI/LO results, ignore rules and reset abort.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int passed = 0;
    int total  = 0;
    int cyc;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle request; returns #1 after the edge that samples it
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        op    = 3'b111;
        A     = 32'h0;
        B     = 32'h0;
    endtask

    // Count cycles with busy=1, bounded so a stuck busy cannot hang the run
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 3'b111;
        A     = 32'h0;
        B     = 32'h0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        reset = 1'b1;
        tick();

        // 1. MULT -3 * 5
        issue(3'b000, 32'hFFFF_FFFD, 32'd5);
        wait_idle(cyc);
        chk("mult_cycles", 32'(cyc), 32'd5);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFF1);

        // 2. MULTU max*max, HI/LO hold while busy
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_busy_t1", 32'(busy), 32'd1);
        chk("multu_hold_hi_t1", HI, 32'hFFFF_FFFF);
        chk("multu_hold_lo_t1", LO, 32'hFFFF_FFF1);
        tick();
        tick();
        tick();
        chk("multu_hold_hi_t4", HI, 32'hFFFF_FFFF);
        chk("multu_hold_lo_t4", LO, 32'hFFFF_FFF1);
        wait_idle(cyc);
        chk("multu_cycles_rest", 32'(cyc), 32'd2);
        chk("multu_hi", HI, 32'hFFFF_FFFE);
        chk("multu_lo", LO, 32'h0000_0001);

        // 3. DIV -7/2, DIVU 7/2, DIV 7/-2
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        chk("div_cycles", 32'(cyc), 32'd10);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        issue(3'b011, 32'd7, 32'd2);
        wait_idle(cyc);
        chk("divu_lo", LO, 32'd3);
        chk("divu_hi", HI, 32'd1);
        issue(3'b010, 32'd7, 32'hFFFF_FFFE);
        wait_idle(cyc);
        chk("div_negb_lo", LO, 32'hFFFF_FFFD);
        chk("div_negb_hi", HI, 32'd1);

        // Overflow case of signed divide
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        chk("div_ovf_lo", LO, 32'h8000_0000);
        chk("div_ovf_hi", HI, 32'h0);

        // 4. MTHI/MTLO then divide by zero
        issue(3'b100, 32'h11, 32'h0);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_hi", HI, 32'h11);
        issue(3'b101, 32'h22, 32'h0);
        chk("mtlo_lo", LO, 32'h22);
        issue(3'b011, 32'd9, 32'd0);
        wait_idle(cyc);
        chk("dz_cycles", 32'(cyc), 32'd10);
        chk("dz_hi", HI, 32'h11);
        chk("dz_lo", LO, 32'h22);

        // Reserved op codes do nothing
        issue(3'b110, 32'h5555, 32'd3);
        chk("op110_busy", 32'(busy), 32'd0);
        issue(3'b111, 32'h5555, 32'd3);
        chk("op111_busy", 32'(busy), 32'd0);
        chk("op11x_hi", HI, 32'h11);
        chk("op11x_lo", LO, 32'h22);

        // 5. DIV 100/7 with an MTLO attempt in T+3, then MULT in T+11
        issue(3'b010, 32'd100, 32'd7);
        tick();
        tick();
        issue(3'b101, 32'hDEAD, 32'h0);
        chk("ign_lo_during", LO, 32'h22);
        wait_idle(cyc);
        chk("ign_cycles_rest", 32'(cyc), 32'd7);
        chk("div100_lo", LO, 32'd14);
        chk("div100_hi", HI, 32'd2);
        issue(3'b000, 32'd3, 32'd4);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_idle(cyc);
        chk("b2b_cycles", 32'(cyc), 32'd5);
        chk("b2b_lo", LO, 32'd12);
        chk("b2b_hi", HI, 32'd0);

        // 6. Reset aborts a running MULT
        issue(3'b000, 32'd6, 32'd7);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", HI, 32'h0);
        chk("abort_lo", LO, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        chk("abort_no_commit", LO, 32'h0);
        issue(3'b001, 32'd2, 32'd3);
        chk("post_rst_busy", 32'(busy), 32'd1);
        wait_idle(cyc);
        chk("post_rst_cycles", 32'(cyc), 32'd5);
        chk("post_rst_lo", LO, 32'd6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
